// File: rtl/pf_vf_mux_pkg.sv
// rtl/pf_vf_mux_pkg.sv - routing table entry type shared with the PF/VF mux fabric
package pf_vf_mux_pkg;

   typedef struct packed {
      logic [2:0]  pf;
      logic [10:0] vf;
      logic        vf_active;
      logic [7:0]  pfvf_port;
   } t_pfvf_rtable_entry;

endpackage

// File: rtl/pf_vf_tlp_router_pkg.sv
// rtl/pf_vf_tlp_router_pkg.sv - header field offsets, wildcards and entry match helper
package pf_vf_tlp_router_pkg;
   import pf_vf_mux_pkg::*;

   localparam int PF_W        = 3;
   localparam int VF_W        = 11;
   localparam int HDR_PF_LSB  = 160;
   localparam int HDR_VF_LSB  = 163;
   localparam int HDR_VFA_BIT = 174;

   localparam logic [PF_W-1:0] PF_WILDCARD = '1;
   localparam logic [VF_W-1:0] VF_WILDCARD = '1;

   function automatic logic match_entry(input t_pfvf_rtable_entry e,
                                        input logic [PF_W-1:0]    pf,
                                        input logic [VF_W-1:0]    vf,
                                        input logic               vfa);
      return ((e.pf == PF_WILDCARD) || (e.pf == pf)) &&
             ((e.vf == VF_WILDCARD) || (e.vf == vf)) &&
             (e.vf_active == vfa);
   endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// rtl/axis_skid_buf.sv - two-entry skid buffer with registered ready
// Slot A drives the output; slot B only fills when A is stalled.
module axis_skid_buf #(
   parameter int PAYLOAD_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [PAYLOAD_W-1:0] in_payload,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [PAYLOAD_W-1:0] out_payload
);

   logic                 a_valid, b_valid, ready_q;
   logic [PAYLOAD_W-1:0] a_data, b_data;
   logic                 in_fire, a_free, b_valid_nxt;

   assign in_fire     = in_valid & ready_q;
   assign a_free      = ~a_valid | out_ready;
   assign in_ready    = ready_q;
   assign out_valid   = a_valid;
   assign out_payload = a_data;

   always_comb begin
      b_valid_nxt = b_valid;
      if (a_free)
         b_valid_nxt = 1'b0;
      else if (in_fire)
         b_valid_nxt = 1'b1;
   end

   // ready_q tracks "B empty" one edge late, so in_fire never coincides with a full B
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_valid <= 1'b0;
         b_valid <= 1'b0;
         ready_q <= 1'b0;
         a_data  <= '0;
         b_data  <= '0;
      end else begin
         ready_q <= ~b_valid_nxt;
         b_valid <= b_valid_nxt;
         if (a_free) begin
            if (b_valid) begin
               a_valid <= 1'b1;
               a_data  <= b_data;
            end else begin
               a_valid <= in_fire;
               if (in_fire)
                  a_data <= in_payload;
            end
         end else if (in_fire) begin
            b_data <= in_payload;
         end
      end
   end

endmodule

// File: rtl/pf_vf_tlp_router.sv
// rtl/pf_vf_tlp_router.sv - classifies host-to-AFU TLPs by PF/VF and tags them with a mux port ID
module pf_vf_tlp_router
   import pf_vf_mux_pkg::*;
   import pf_vf_tlp_router_pkg::*;
#(
   parameter int                                   NUM_ENTRIES = 4,
   parameter int                                   NID_WIDTH   = 1,
   parameter t_pfvf_rtable_entry [NUM_ENTRIES-1:0] RTABLE      = '0,
   parameter int                                   DATA_W      = 512,
   parameter int                                   USER_W      = 10,
   parameter int                                   PF_LSB      = HDR_PF_LSB,
   parameter int                                   VF_LSB      = HDR_VF_LSB,
   parameter int                                   VFA_BIT     = HDR_VFA_BIT
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rx_tvalid,
   output logic                 rx_tready,
   input  logic [DATA_W-1:0]    rx_tdata,
   input  logic [USER_W-1:0]    rx_tuser,
   input  logic                 rx_tlast,
   output logic                 tx_tvalid,
   input  logic                 tx_tready,
   output logic [DATA_W-1:0]    tx_tdata,
   output logic [USER_W-1:0]    tx_tuser,
   output logic                 tx_tlast,
   output logic [NID_WIDTH-1:0] tx_tid,
   output logic [15:0]          miss_cnt,
   input  logic                 miss_clr
);

   localparam int PAYLOAD_W = NID_WIDTH + 1 + USER_W + DATA_W;

   logic                 in_pkt;
   logic [NID_WIDTH-1:0] route_q;
   logic [15:0]          miss_cnt_q;
   logic                 rx_fire, sop;
   logic [PF_W-1:0]      hdr_pf;
   logic [VF_W-1:0]      hdr_vf;
   logic                 hdr_vfa;
   logic                 lut_hit;
   logic [NID_WIDTH-1:0] lut_port, beat_tid;

   assign rx_fire  = rx_tvalid & rx_tready;
   assign sop      = ~in_pkt;
   assign hdr_pf   = rx_tdata[PF_LSB +: PF_W];
   assign hdr_vf   = rx_tdata[VF_LSB +: VF_W];
   assign hdr_vfa  = rx_tdata[VFA_BIT];
   assign beat_tid = sop ? lut_port : route_q;
   assign miss_cnt = miss_cnt_q;

   // Scan high to low so the lowest matching index is the one left standing
   always_comb begin
      lut_hit  = 1'b0;
      lut_port = '0;
      for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
         if (match_entry(RTABLE[i], hdr_pf, hdr_vf, hdr_vfa)) begin
            lut_hit  = 1'b1;
            lut_port = RTABLE[i].pfvf_port[NID_WIDTH-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_pkt     <= 1'b0;
         route_q    <= '0;
         miss_cnt_q <= '0;
      end else begin
         if (rx_fire) begin
            in_pkt <= ~rx_tlast;
            if (sop)
               route_q <= lut_port;
         end
         if (miss_clr)
            miss_cnt_q <= '0;
         else if (rx_fire && sop && !lut_hit && (miss_cnt_q != 16'hFFFF))
            miss_cnt_q <= miss_cnt_q + 16'd1;
      end
   end

   axis_skid_buf #(
      .PAYLOAD_W (PAYLOAD_W)
   ) u_skid (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (rx_tvalid),
      .in_ready    (rx_tready),
      .in_payload  ({beat_tid, rx_tlast, rx_tuser, rx_tdata}),
      .out_valid   (tx_tvalid),
      .out_ready   (tx_tready),
      .out_payload ({tx_tid, tx_tlast, tx_tuser, tx_tdata})
   );

endmodule

// File: tb/tb_pf_vf_tlp_router.sv
// tb/tb_pf_vf_tlp_router.sv - scoreboard bench for pf_vf_tlp_router
module tb_pf_vf_tlp_router;
   import pf_vf_mux_pkg::*;

   typedef struct packed {
      logic [511:0] data;
      logic [9:0]   user;
      logic         last;
      logic         tid;
   } beat_t;

   function automatic t_pfvf_rtable_entry mk_e(input int pf, input int vf, input int va, input int port);
      t_pfvf_rtable_entry e;
      e.pf        = pf[2:0];
      e.vf        = vf[10:0];
      e.vf_active = va[0];
      e.pfvf_port = port[7:0];
      return e;
   endfunction

   localparam t_pfvf_rtable_entry [3:0] TBL_A = {mk_e(7, 2047, 1, 0), mk_e(7, 2047, 0, 0),
                                                 mk_e(0, 0, 1, 1),    mk_e(0, 0, 0, 0)};
   localparam t_pfvf_rtable_entry [3:0] TBL_B = {mk_e(4, 9, 1, 1), mk_e(1, 3, 0, 0),
                                                 mk_e(1, 3, 0, 1), mk_e(0, 0, 1, 1)};

   // Reference tables: pf 7 / vf 2047 mean "any"
   int ref_pf[2][4]   = '{'{0, 0, 7, 7},    '{0, 1, 1, 4}};
   int ref_vf[2][4]   = '{'{0, 0, 2047, 2047}, '{0, 3, 3, 9}};
   int ref_va[2][4]   = '{'{0, 1, 0, 1},    '{1, 0, 0, 1}};
   int ref_port[2][4] = '{'{0, 1, 0, 0},    '{1, 1, 0, 1}};

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   int           sel = 0;
   logic         rx_tvalid = 1'b0;
   logic [511:0] rx_tdata = '0;
   logic [9:0]   rx_tuser = '0;
   logic         rx_tlast = 1'b0;
   logic         tx_tready = 1'b1;
   logic         miss_clr_v [2];
   logic         rx_tvalid_v [2];
   logic         rx_tready_v [2];
   logic         tx_tvalid_v [2];
   logic [511:0] tx_tdata_v [2];
   logic [9:0]   tx_tuser_v [2];
   logic         tx_tlast_v [2];
   logic [0:0]   tx_tid_v [2];
   logic [15:0]  miss_cnt_v [2];

   int    n_checks = 0;
   int    n_errors = 0;
   int    miss_model [2];
   bit    rand_ready = 0;
   beat_t exp_q [2][$];

   assign rx_tvalid_v[0] = rx_tvalid && (sel == 0);
   assign rx_tvalid_v[1] = rx_tvalid && (sel == 1);

   always #5 clk = ~clk;

   pf_vf_tlp_router #(.NUM_ENTRIES(4), .NID_WIDTH(1), .RTABLE(TBL_A)) u_dut_a (
      .clk(clk), .rst_n(rst_n),
      .rx_tvalid(rx_tvalid_v[0]), .rx_tready(rx_tready_v[0]), .rx_tdata(rx_tdata),
      .rx_tuser(rx_tuser), .rx_tlast(rx_tlast),
      .tx_tvalid(tx_tvalid_v[0]), .tx_tready(tx_tready), .tx_tdata(tx_tdata_v[0]),
      .tx_tuser(tx_tuser_v[0]), .tx_tlast(tx_tlast_v[0]), .tx_tid(tx_tid_v[0]),
      .miss_cnt(miss_cnt_v[0]), .miss_clr(miss_clr_v[0]));

   pf_vf_tlp_router #(.NUM_ENTRIES(4), .NID_WIDTH(1), .RTABLE(TBL_B)) u_dut_b (
      .clk(clk), .rst_n(rst_n),
      .rx_tvalid(rx_tvalid_v[1]), .rx_tready(rx_tready_v[1]), .rx_tdata(rx_tdata),
      .rx_tuser(rx_tuser), .rx_tlast(rx_tlast),
      .tx_tvalid(tx_tvalid_v[1]), .tx_tready(tx_tready), .tx_tdata(tx_tdata_v[1]),
      .tx_tuser(tx_tuser_v[1]), .tx_tlast(tx_tlast_v[1]), .tx_tid(tx_tid_v[1]),
      .miss_cnt(miss_cnt_v[1]), .miss_clr(miss_clr_v[1]));

   task automatic chk(input bit ok, input string name, input string act, input string exp);
      n_checks++;
      if (!ok) begin
         n_errors++;
         $display("FAIL %s: got %s, expected %s", name, act, exp);
      end
   endtask

   function automatic string fmt(input beat_t b);
      return $sformatf("tid=%0d last=%0d user=%h data=%h", b.tid, b.last, b.user, b.data);
   endfunction

   function automatic logic [511:0] rand512();
      logic [511:0] d;
      for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
      return d;
   endfunction

   function automatic logic [511:0] mk_hdr(input int pf, input int vf, input int va);
      logic [511:0] d;
      d = rand512();
      d[162:160] = pf[2:0];
      d[173:163] = vf[10:0];
      d[174]     = va[0];
      return d;
   endfunction

   function automatic int ref_route(input int k, input int pf, input int vf, input int va, output bit hit);
      hit = 0;
      for (int i = 0; i < 4; i++)
         if ((ref_pf[k][i] == 7 || ref_pf[k][i] == pf) &&
             (ref_vf[k][i] == 2047 || ref_vf[k][i] == vf) && ref_va[k][i] == va) begin
            hit = 1;
            return ref_port[k][i];
         end
      return 0;
   endfunction

   // Called and returns on a falling edge
   task automatic send_beat(input int k, input beat_t b);
      bit acc = 0;
      int n = 0;
      sel = k; rx_tdata = b.data; rx_tuser = b.user; rx_tlast = b.last; rx_tvalid = 1'b1;
      while (!acc && n < 200) begin
         acc = rx_tready_v[k];
         @(posedge clk);
         if (acc) exp_q[k].push_back(b);
         n++;
         @(negedge clk);
      end
      rx_tvalid = 1'b0;
      if (!acc) chk(0, "accept_timeout", "rx_tready low 200 cycles", "beat accepted");
   endtask

   task automatic send_pkt(input int k, input int nb, input int pf, input int vf, input int va, input bit gaps);
      bit    hit;
      int    port;
      beat_t b;
      port = ref_route(k, pf, vf, va, hit);
      if (!hit && miss_model[k] < 16'hFFFF) miss_model[k]++;
      for (int i = 0; i < nb; i++) begin
         if (i == 0)          b.data = mk_hdr(pf, vf, va);
         else if (i % 2 == 1) b.data = mk_hdr(0, 0, 1 - va);
         else                 b.data = rand512();
         b.user = 10'($urandom);
         b.last = (i == nb - 1);
         b.tid  = port[0];
         send_beat(k, b);
         if (gaps && $urandom_range(0, 3) == 0) @(negedge clk);
      end
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((exp_q[0].size() != 0 || exp_q[1].size() != 0) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk(n < 2000, "drain", $sformatf("%0d/%0d beats outstanding", exp_q[0].size(), exp_q[1].size()), "0/0");
      @(negedge clk);
   endtask

   task automatic chk_miss(input int k, input string name);
      chk(miss_cnt_v[k] == miss_model[k][15:0], name,
          $sformatf("miss_cnt=%h", miss_cnt_v[k]), $sformatf("%h", miss_model[k][15:0]));
   endtask

   task automatic chk_reset_vals(input string name);
      for (int k = 0; k < 2; k++)
         chk(tx_tvalid_v[k] == 0 && rx_tready_v[k] == 0 && tx_tid_v[k] == 0 &&
             tx_tlast_v[k] == 0 && miss_cnt_v[k] == 0, $sformatf("%s_%0d", name, k),
             $sformatf("tvalid=%0d rready=%0d tid=%0d tlast=%0d miss=%h", tx_tvalid_v[k],
                       rx_tready_v[k], tx_tid_v[k], tx_tlast_v[k], miss_cnt_v[k]),
             "all zero");
   endtask

   initial begin
      beat_t b;
      miss_clr_v[0] = 1'b0;
      miss_clr_v[1] = 1'b0;
      miss_model[0] = 0;
      miss_model[1] = 0;

      fork
         begin : watchdog
            #3000000;
            $display("FAIL watchdog: got time limit reached, expected completion");
            $fatal(1, "watchdog");
         end
         forever begin
            @(posedge clk);
            #1 tx_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         end
         begin : monitor
            bit    stall [2];
            beat_t held [2];
            beat_t cur, e;
            stall[0] = 0;
            stall[1] = 0;
            forever begin
               @(negedge clk);
               for (int k = 0; k < 2; k++) begin
                  if (!rst_n) begin
                     stall[k] = 0;
                     continue;
                  end
                  cur = '{data: tx_tdata_v[k], user: tx_tuser_v[k], last: tx_tlast_v[k], tid: tx_tid_v[k]};
                  if (stall[k])
                     chk(tx_tvalid_v[k] && cur == held[k], $sformatf("stall_stable_%0d", k),
                         $sformatf("tvalid=%0d %s", tx_tvalid_v[k], fmt(cur)), fmt(held[k]));
                  if (tx_tvalid_v[k] && tx_tready) begin
                     if (exp_q[k].size() == 0) begin
                        chk(0, $sformatf("unexpected_beat_%0d", k), fmt(cur), "no beat");
                     end else begin
                        e = exp_q[k].pop_front();
                        chk(cur == e, $sformatf("egress_%0d", k), fmt(cur), fmt(e));
                     end
                  end
                  stall[k] = tx_tvalid_v[k] && !tx_tready;
                  held[k]  = cur;
               end
            end
         end
      join_none

      // Reset state and ready release
      repeat (2) @(negedge clk);
      chk_reset_vals("reset_state");
      rst_n = 1'b1;
      chk(rx_tready_v[0] == 0, "ready_before_edge", $sformatf("%0d", rx_tready_v[0]), "0");
      @(negedge clk);
      chk(rx_tready_v[0] == 1, "ready_after_edge", $sformatf("%0d", rx_tready_v[0]), "1");

      // Directed routing on table A
      send_pkt(0, 1, 0, 0, 1, 0);
      send_pkt(0, 1, 0, 0, 0, 0);
      send_pkt(0, 4, 0, 0, 1, 0);
      send_pkt(0, 2, 5, 100, 1, 0);
      wait_drain();
      chk_miss(0, "miss_a_none");

      // Misses on table B, then clear colliding with a miss
      send_pkt(1, 1, 2, 0, 0, 0);
      wait_drain();
      chk_miss(1, "miss_b_one");
      miss_clr_v[1] = 1'b1;
      b = '{data: mk_hdr(2, 0, 0), user: 10'h155, last: 1'b1, tid: 1'b0};
      send_beat(1, b);
      miss_clr_v[1] = 1'b0;
      miss_model[1] = 0;
      wait_drain();
      chk_miss(1, "miss_clr_priority");
      send_pkt(1, 1, 1, 3, 0, 0);
      send_pkt(1, 3, 4, 9, 1, 0);
      wait_drain();
      chk_miss(1, "miss_b_hits");

      // Random traffic with 50% egress backpressure
      rand_ready = 1;
      for (int p = 0; p < 1000; p++) begin
         int pfs [5] = '{0, 1, 2, 4, 7};
         int vfs [4] = '{0, 3, 9, 0};
         int pf, vf;
         pf = pfs[$urandom_range(0, 4)];
         vfs[3] = $urandom_range(0, 2047);
         vf = vfs[$urandom_range(0, 3)];
         send_pkt($urandom_range(0, 1), $urandom_range(1, 8), pf, vf, $urandom_range(0, 1), 1);
      end
      wait_drain();
      rand_ready = 0;
      chk_miss(0, "miss_a_random");
      chk_miss(1, "miss_b_random");

      // Reset in the middle of a 4-beat packet routed to port 0
      repeat (2) @(negedge clk);
      b = '{data: mk_hdr(0, 0, 0), user: 10'h001, last: 1'b0, tid: 1'b0};
      send_beat(0, b);
      b = '{data: mk_hdr(0, 0, 0), user: 10'h002, last: 1'b0, tid: 1'b0};
      send_beat(0, b);
      @(negedge clk);
      rst_n = 1'b0;
      exp_q[0].delete();
      exp_q[1].delete();
      miss_model[0] = 0;
      miss_model[1] = 0;
      #1;
      chk_reset_vals("midpkt_reset");
      @(negedge clk);
      rst_n = 1'b1;
      send_pkt(0, 1, 0, 0, 1, 0);
      wait_drain();

      // Saturation from a preloaded count
      @(negedge clk);
      force u_dut_b.miss_cnt_q = 16'hFFFE;
      #1;
      release u_dut_b.miss_cnt_q;
      miss_model[1] = 16'hFFFE;
      for (int i = 0; i < 3; i++) begin
         send_pkt(1, 1, 2, 5, 1, 0);
         wait_drain();
         chk_miss(1, $sformatf("miss_sat_%0d", i));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/pf_vf_tlp_router.md
# pf_vf_tlp_router

Ingress routing stage that feeds the PF/VF mux fabric in afu_top. It classifies every host-to-AFU TLP by its PF number, VF number and VF-active bit against the routing table produced by top_cfg_pkg::get_pf_vf_entry_info(), or get_prr_pf_vf_entry_info() for the PR-side instance. It then forwards the whole packet with a mux port ID on tx_tid. The route is resolved on the SOP beat and held for the remaining beats of the packet. Table misses are counted.

## Interface
- NUM_ENTRIES, 4: routing table depth (NUM_RTABLE_ENTRIES).
- NID_WIDTH, 1: port-ID width; equals $clog2(NUM_PORT).
- RTABLE, all-zero: table of NUM_ENTRIES pf_vf_mux_pkg::t_pfvf_rtable_entry.
- DATA_W, 512: tdata width.
- USER_W, 10: tuser width.
- PF_LSB, 160: header bit offset of the 3-bit PF field.
- VF_LSB, 163: header bit offset of the 11-bit VF field.
- VFA_BIT, 174: header bit position of vf_active.

Ports:
- clk  in  1  sole clock.
- rst_n  in  1  asynchronous, active-low reset.
- rx_tvalid / rx_tready  in / out  1  ingress handshake.
- rx_tdata  in  DATA_W  ingress data; beat 0 carries the header.
- rx_tuser  in  USER_W  ingress sideband, passed through.
- rx_tlast  in  1  end of packet.
- tx_tvalid / tx_tready  out / in  1  egress handshake.
- tx_tdata, tx_tuser, tx_tlast  out  as ingress  registered copies of the ingress beat.
- tx_tid  out  NID_WIDTH  destination mux port, constant across a packet.
- miss_cnt  out  16  count of SOP beats that matched no table entry; saturates.
- miss_clr  in  1  synchronous clear of miss_cnt.

## Operation
- SOP tracking: the in_pkt flag sets on an accepted beat with rx_tlast=0 and clears on an accepted beat with rx_tlast=1. A beat is SOP when in_pkt=0. Single-beat packets leave in_pkt at 0.
- Match rule for entry e:
  - PF term: e.pf is all-ones (wildcard) or e.pf equals hdr PF.
  - VF term: e.vf is all-ones (wildcard) or e.vf equals hdr VF.
  - VF-active term: e.vf_active equals hdr vf_active.
  - An entry matches when all three terms hold.
- Priority: the lowest matching index wins. Its pfvf_port (truncated to NID_WIDTH) becomes the route.
- No match: the route is 0 and miss_cnt increments by 1, saturating at 0xFFFF.
- Route register: loaded on every accepted SOP beat. Non-SOP beats use the held route, not a new lookup.
- Buffering: a two-entry skid buffer, with slot A as the output register and slot B as the overflow slot. Each entry stores data, user, last and tid.
- rx_tready is the registered value of "slot B empty". Beats are never dropped or reordered.
- miss_clr has priority over an increment in the same cycle; the counter becomes 0.
- Reset mid-packet: in_pkt, route, the buffers and miss_cnt all clear. The next accepted beat is treated as SOP.

## Timing
- Reset values: tx_tvalid=0, rx_tready=0, tx_tid=0, tx_tlast=0, miss_cnt=0. tx_tdata and tx_tuser are don't-care.
- rx_tready rises on the first clk edge after rst_n deasserts.
- Latency: a beat accepted at edge N appears on tx_* after edge N. With tx_tready held high, throughput is one beat per clock.
- When tx_tready=0 with slot A full, one more beat is absorbed into slot B. rx_tready then drops on the next edge.
- Drain order: A is sent first, then B moves to A. rx_tready returns the cycle after B empties.
- tx_tvalid and the tx_* payload stay stable while tx_tvalid=1 and tx_tready=0.
- miss_cnt updates one edge after the missing SOP beat is accepted.

## Structure
- A dedicated router package holds the helper function match_entry(), the all-ones wildcard constants for pf and vf, and the header field offsets.
- The table typedef stays in pf_vf_mux_pkg.
- Sub-module axis_skid_buf: parameterised payload width, two entries, registered ready. It carries {tid, last, user, data}.

## Test plan
- Table {pf0/vf0/va0 → 0, pf0/vf0/va1 → 1, wildcard/va0 → 0, wildcard/va1 → 0}:
  - SOP with PF0 VF0 va=1 → tx_tid=1, miss_cnt=0.
  - SOP with PF0 VF0 va=0 → tx_tid=0.
- 4-beat packet with PF0 VF0 va=1 whose body beats carry garbage in the header field positions → tx_tid=1 on all 4 beats.
- Table with no wildcard rows, SOP with PF2 → tx_tid=0 and miss_cnt=1. Then pulse miss_clr in the same cycle as another miss → miss_cnt=0.
- Random tx_tready at 50% duty over 1000 packets of 1–8 beats → egress data, order and tid match the scoreboard exactly. tx_* stays stable while stalled.
- Reset asserted mid-packet after beat 2 of 4 → all outputs at reset values. The next beat is classified as SOP using its own header.
- Force miss_cnt to 0xFFFE, then send 3 misses → miss_cnt holds at 0xFFFF.
